inflight_tag_tracker: RTL
=========================

Name: inflight_tag_tracker

Overview:
- Parametrised successor to the finish detector and the tag-retire hazard logic: one block tracks every ROB tag from issue to final release.
- Supports NUM_ISSUE issue ports and NUM_COMMIT commit ports per cycle.
- Holds each memory-op tag until both commit and LSQ release have occurred, then returns it to the IDU through a one-per-cycle retire FIFO.
- Runs the end-of-program FSM: drain, finish, flush-abort and watchdog timeout. Sits beside the ROB/IDU at the CPU top level.

Parameters:
TAG_W, 5, tag width (ROB_SIZE_WIDTH); NUM_TAGS = 2**TAG_W
NUM_ISSUE, 1, issue ports per cycle
NUM_COMMIT, 2, commit ports per cycle
RET_DEPTH, 8, retire FIFO depth (power of 2, >= NUM_COMMIT+1)
WDOG_W, 16, drain watchdog counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
issue_valid  in  NUM_ISSUE  per-port issue strobe
issue_tag  in  NUM_ISSUE*TAG_W  issued tags, port i at [i*TAG_W +: TAG_W]
issue_mem_op  in  NUM_ISSUE  issued op is load/store
commit_valid  in  NUM_COMMIT  per-port commit strobe
commit_tag  in  NUM_COMMIT*TAG_W  committed tags
lsq_retire_valid  in  1  LSQ freed its entry
lsq_retire_tag  in  TAG_W  tag of freed LSQ entry
flush  in  1  mispredict flush
seen_last_inst  in  1  fetch saw final instruction
retire_tag_valid  out  1  a tag is returned to the IDU this cycle
retire_tag  out  TAG_W  returned tag
commit_hold  out  1  retire FIFO free slots < NUM_COMMIT+1
inflight_count  out  TAG_W+1  tags currently tracked
finish  out  1  program complete (level)
timeout  out  1  drain watchdog expired (level)
tag_err  out  1  sticky protocol error

Behaviour:
- Reset (async) values:
  - per-tag bits inflight, committed, mem_pend all 0; FIFO empty; FSM RUN.
  - All outputs 0.
- Issue: sets inflight[tag]=1, committed=0, mem_pend=issue_mem_op.
  - Issuing a tag already inflight sets tag_err.
- Commit port, tag inflight:
  - mem_pend=0: release the tag (clear inflight, push to FIFO).
  - mem_pend=1: set committed=1 and hold the tag.
  - Commit of a tag that is not inflight, or a duplicate tag across ports in one cycle: tag_err.
- LSQ retire:
  - If committed=1: release.
  - Else: clear mem_pend only; a later commit releases the tag.
  - LSQ retire of a tag that is not inflight: tag_err.
- Same-cycle ordering: commit ports in ascending index, then LSQ retire, then issue.
  - A commit and an LSQ retire of the same held tag in one cycle releases it exactly once.
- FIFO:
  - Up to NUM_COMMIT+1 pushes per cycle, written in the ordering above.
  - One pop per cycle whenever non-empty; no ready input.
  - retire_tag_valid/retire_tag driven from the head register.
  - Latency: release at cycle t -> retire_tag_valid at t+1 if the FIFO was empty.
  - Pointers wrap modulo RET_DEPTH. Simultaneous push and pop is allowed at full.
  - Pushes beyond free slots are dropped and set tag_err.
- commit_hold is registered, computed from next-state occupancy.
- Flush: clears inflight for all tags with committed=0, no push.
  - Committed tags with mem_pend=1 stay held.
  - Flush wins over same-cycle issue. Same-cycle commits still process.
- inflight_count = popcount(inflight), registered.
- FSM:
  - RUN: seen_last_inst -> DRAIN; watchdog counter cleared.
  - DRAIN:
    - Counter increments every cycle.
    - flush -> RUN.
    - inflight_count==0 && FIFO empty && no issue_valid -> DONE.
    - Counter all-ones -> TIMEOUT.
    - DONE has priority over TIMEOUT on the same cycle.
  - DONE: finish=1, held until reset.
  - TIMEOUT: finish=1, timeout=1, held until reset.
- Reset mid-operation: everything returns to reset values immediately; in-flight tags are discarded.

Decomposition:
- Shared package tag_tracker_pkg holds:
  - finish_state_t enum {RUN, DRAIN, DONE, TIMEOUT};
  - tag_t;
  - per-tag status struct {inflight, committed, mem_pend}.
- TAG_W defaults from `ROB_SIZE_WIDTH.
- Sub-module retire_tag_fifo, parametrised by width, depth and push count: multi-push/single-pop FIFO with free-slot count output.

Test Plan:
- Issue tag 3 (non-mem); commit tag 3 at cycle 10 -> retire_tag_valid=1, retire_tag=3 at cycle 11; inflight_count 1->0.
- Issue tag 5 (mem), commit at 10, LSQ retire at 14 -> no retire before 15; retire_tag=5 at 15. Reverse order (LSQ at 10, commit at 14) -> retire at 15.
- NUM_COMMIT=2: commit tags 1,2 plus LSQ retire of committed tag 7 in one cycle -> retire_tag 1,2,7 on three consecutive cycles; commit_hold reflects occupancy 3.
- Issue tags 0..4; commit 0; LSQ-hold tag 2 (mem, committed); flush -> inflight_count=1, tag 2 still released on later LSQ retire; tag_err=0.
- seen_last_inst, then drain of all tags -> finish=1 the cycle after the last FIFO pop. With WDOG_W=4 and a tag never committed -> timeout=1, finish=1 after 15 DRAIN cycles. Flush in DRAIN -> back to RUN, finish stays 0.
- Error cases: commit of an un-issued tag, or a double issue of tag 9 -> tag_err=1, sticky until reset. Async reset asserted mid-drain -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/tag_tracker_pkg.sv
// tag_tracker_pkg: shared types for the in-flight tag tracker
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 5
`endif
package tag_tracker_pkg;
  localparam int TAG_W_DEF = `ROB_SIZE_WIDTH;
  typedef enum logic [1:0] {RUN, DRAIN, DONE, TIMEOUT} finish_state_t;
  typedef logic [TAG_W_DEF-1:0] tag_t;
  typedef struct packed {
    logic inflight;
    logic committed;
    logic mem_pend;
  } tag_status_t;
endpackage

// File: rtl/inflight_tag_tracker_retire_tag_fifo.sv
// retire_tag_fifo: multi-push single-pop FIFO that pops every cycle it is non-empty
module retire_tag_fifo #(
  parameter int W = 5,
  parameter int DEPTH = 8,
  parameter int NPUSH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPUSH-1:0]         push_valid,
  input  logic [NPUSH*W-1:0]       push_data,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  output logic [$clog2(DEPTH):0]   free_slots,
  output logic                     drop
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0] count_q, count_d;
  logic pop;
  always_comb begin
    mem_d = mem_q;
    pop = count_q != '0;
    rd_d = rd_q + PW'(pop);
    count_d = count_q - (PW+1)'(pop);
    drop = 1'b0;
    for (int i = 0; i < NPUSH; i++) begin
      if (push_valid[i]) begin
        if (count_d < (PW+1)'(DEPTH)) begin
          mem_d[rd_d + count_d[PW-1:0]] = push_data[i*W +: W];
          count_d = count_d + (PW+1)'(1);
        end else drop = 1'b1;
      end
    end
  end
  assign out_valid = count_q != '0;
  assign out_data = out_valid ? mem_q[rd_q] : '0;
  assign free_slots = (PW+1)'(DEPTH) - count_d;
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q <= '0;
      count_q <= '0;
    end else begin
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/inflight_tag_tracker.sv
// inflight_tag_tracker: tracks ROB tags from issue to release and runs the end-of-program FSM
module inflight_tag_tracker
  import tag_tracker_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF,
  parameter int NUM_ISSUE = 1,
  parameter int NUM_COMMIT = 2,
  parameter int RET_DEPTH = 8,
  parameter int WDOG_W = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_ISSUE-1:0]        issue_valid,
  input  logic [NUM_ISSUE*TAG_W-1:0]  issue_tag,
  input  logic [NUM_ISSUE-1:0]        issue_mem_op,
  input  logic [NUM_COMMIT-1:0]       commit_valid,
  input  logic [NUM_COMMIT*TAG_W-1:0] commit_tag,
  input  logic                        lsq_retire_valid,
  input  logic [TAG_W-1:0]            lsq_retire_tag,
  input  logic                        flush,
  input  logic                        seen_last_inst,
  output logic                        retire_tag_valid,
  output logic [TAG_W-1:0]            retire_tag,
  output logic                        commit_hold,
  output logic [TAG_W:0]              inflight_count,
  output logic                        finish,
  output logic                        timeout,
  output logic                        tag_err
);
  localparam int NUM_TAGS = 2**TAG_W;
  localparam int NP = NUM_COMMIT + 1;
  localparam int CW = $clog2(RET_DEPTH) + 1;
  tag_status_t st_q [NUM_TAGS];
  tag_status_t st_d [NUM_TAGS];
  finish_state_t state_q, state_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [TAG_W:0] cnt_q, cnt_d;
  logic hold_q, hold_d, err_q, err, finish_q, timeout_q;
  logic [NP-1:0] push_valid;
  logic [NP*TAG_W-1:0] push_data;
  logic [CW-1:0] fifo_free_d;
  logic fifo_drop, dup;
  logic [TAG_W-1:0] t;
  retire_tag_fifo #(.W(TAG_W), .DEPTH(RET_DEPTH), .NPUSH(NP)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push_valid(push_valid),
    .push_data(push_data),
    .out_valid(retire_tag_valid),
    .out_data(retire_tag),
    .free_slots(fifo_free_d),
    .drop(fifo_drop)
  );
  always_comb begin
    st_d = st_q;
    push_valid = '0;
    push_data = '0;
    err = 1'b0;
    dup = 1'b0;
    t = '0;
    for (int i = 0; i < NUM_COMMIT; i++) begin
      t = commit_tag[i*TAG_W +: TAG_W];
      dup = 1'b0;
      for (int j = 0; j < i; j++) dup = dup | (commit_valid[j] && commit_tag[j*TAG_W +: TAG_W] == t);
      if (commit_valid[i]) begin
        if (dup || !st_d[t].inflight) err = 1'b1;
        else if (!st_d[t].mem_pend) begin
          st_d[t] = '0;
          push_valid[i] = 1'b1;
          push_data[i*TAG_W +: TAG_W] = t;
        end else st_d[t].committed = 1'b1;
      end
    end
    t = lsq_retire_tag;
    if (lsq_retire_valid) begin
      if (!st_d[t].inflight) err = 1'b1;
      else if (st_d[t].committed) begin
        st_d[t] = '0;
        push_valid[NUM_COMMIT] = 1'b1;
        push_data[NUM_COMMIT*TAG_W +: TAG_W] = t;
      end else st_d[t].mem_pend = 1'b0;
    end
    if (flush) begin
      for (int k = 0; k < NUM_TAGS; k++) if (!st_d[k].committed) st_d[k] = '0;
    end else begin
      for (int i = 0; i < NUM_ISSUE; i++) begin
        t = issue_tag[i*TAG_W +: TAG_W];
        if (issue_valid[i]) begin
          err = err | st_d[t].inflight;
          st_d[t] = '{inflight: 1'b1, committed: 1'b0, mem_pend: issue_mem_op[i]};
        end
      end
    end
    cnt_d = '0;
    for (int k = 0; k < NUM_TAGS; k++) cnt_d = cnt_d + (TAG_W+1)'(st_d[k].inflight);
    hold_d = fifo_free_d < CW'(NP);
    state_d = state_q;
    wdog_d = '0;
    if (state_q == RUN) state_d = seen_last_inst ? DRAIN : RUN;
    else if (state_q == DRAIN) begin
      wdog_d = wdog_q + WDOG_W'(1);
      state_d = flush ? RUN
              : (cnt_d == '0 && fifo_free_d == CW'(RET_DEPTH) && !(|issue_valid)) ? DONE
              : (&wdog_d) ? TIMEOUT : DRAIN;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= '{default: '0};
      state_q <= RUN;
      wdog_q <= '0;
      cnt_q <= '0;
      hold_q <= 1'b0;
      err_q <= 1'b0;
      finish_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      st_q <= st_d;
      state_q <= state_d;
      wdog_q <= wdog_d;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
      err_q <= err_q | err | fifo_drop;
      finish_q <= (state_d == DONE) || (state_d == TIMEOUT);
      timeout_q <= state_d == TIMEOUT;
    end
  end
  assign commit_hold = hold_q;
  assign inflight_count = cnt_q;
  assign finish = finish_q;
  assign timeout = timeout_q;
  assign tag_err = err_q;
endmodule
